stack_engine: RTL and testbench

//  Downstream consumer of the interrupt control unit's stack_op/push_pop/reg_id command stream.

---
 rtl/stack_engine_pkg.sv | 36 +++
 rtl/stack_cmd_fifo.sv | 55 +++++
 rtl/stack_engine.sv | 174 +++++++++++++++++
 tb/tb_stack_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_engine_pkg.sv
// Shared types and constants for the stack engine and its command queue.
package stack_engine_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int QDEPTH = 4;
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = $clog2(QDEPTH) + 1;

  // Empty-stack pointer; the stack grows downward from here.
  localparam logic [ADDR_W-1:0] SP_INIT  = 12'hFFF;
  // Lowest address a push may write.
  localparam logic [ADDR_W-1:0] SP_LIMIT = 12'hC00;

  localparam logic [3:0] PCL_ID = 4'd8;
  localparam logic [3:0] PCH_ID = 4'd9;
  localparam logic [3:0] CCR_ID = 4'd10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // One queued stack command; push data is captured when the command is accepted.
  typedef struct packed {
    logic              push;
    logic [3:0]        reg_id;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // GPRs 0-7 plus PCL, PCH and CCR are the only stackable registers.
  function automatic logic reg_id_legal(input logic [3:0] id);
    return (id <= CCR_ID);
  endfunction

endpackage

// File: rtl/stack_cmd_fifo.sv
// Small synchronous FIFO holding pending stack commands.
module stack_cmd_fifo
  import stack_engine_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  cmd_t             i_wr_cmd,
  input  logic             i_rd_en,
  output cmd_t             o_rd_cmd,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  cmd_t             r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full   = (r_count == CNT_W'(QDEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rd_cmd = r_mem[r_rd_ptr];
  assign w_do_wr  = i_wr_en & ~o_full;
  assign w_do_rd  = i_rd_en & ~o_empty;

  // Pointer and occupancy bookkeeping; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Command storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_cmd;
  end

endmodule

// File: rtl/stack_engine.sv
// Stack engine: queues push/pop commands, owns the stack pointer and
// drives one data-memory access at a time, returning popped words.
module stack_engine
  import stack_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_stack_op,
  input  logic              i_push_pop,
  input  logic [3:0]        i_reg_id,
  input  logic [DATA_W-1:0] i_gpr_in,
  input  logic [31:0]       i_pc_in,
  input  logic [3:0]        i_ccr_in,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_pop_valid,
  output logic [3:0]        o_pop_reg_id,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_sp_out,
  output logic              o_ovf_err,
  output logic              o_unf_err,
  output logic              o_cmd_err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;
  logic [3:0]        r_cur_reg;
  logic              r_pop_valid;
  logic [3:0]        r_pop_reg_id;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_ovf_err;
  logic              r_unf_err;
  logic              r_cmd_err;

  logic [DATA_W-1:0] w_push_data;
  cmd_t              w_wr_cmd;
  cmd_t              w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_legal;
  logic              w_enq;
  logic              w_bad_cmd;
  logic              w_deq;
  logic              w_ovf_hit;
  logic              w_unf_hit;

  // Snapshot of the register being pushed, chosen by reg_id.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    w_push_data = i_gpr_in;
    case (i_reg_id)
      PCL_ID:  w_push_data = i_pc_in[15:0];
      PCH_ID:  w_push_data = i_pc_in[31:16];
      CCR_ID:  w_push_data = {{(DATA_W-4){1'b0}}, i_ccr_in};
      default: ;
    endcase
  end

  assign w_wr_cmd  = '{push: i_push_pop, reg_id: i_reg_id, data: w_push_data};
  assign w_legal   = reg_id_legal(i_reg_id);
  assign w_enq     = i_enable & i_stack_op & w_legal & ~w_full;
  assign w_bad_cmd = i_enable & i_stack_op & (~w_legal | w_full);
  assign w_deq     = i_enable & (r_state == ST_IDLE) & ~w_empty;

  // Guards evaluated on the queue head at the moment it is dequeued.
  assign w_ovf_hit = w_head.push & (r_sp < SP_LIMIT);
  assign w_unf_hit = ~w_head.push & (r_sp == SP_INIT);

  stack_cmd_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (~i_enable),
    .i_wr_en  (w_enq),
    .i_wr_cmd (w_wr_cmd),
    .i_rd_en  (w_deq),
    .o_rd_cmd (w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Access FSM: dequeue and check in IDLE, hold the request in ACCESS until mem_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sp         <= SP_INIT;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_cur_reg    <= '0;
      r_pop_valid  <= 1'b0;
      r_pop_reg_id <= '0;
      r_pop_data   <= '0;
      r_ovf_err    <= 1'b0;
      r_unf_err    <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      if (!i_enable) begin
        // Abandon any access in flight; SP and sticky errors are left alone.
        r_state  <= ST_IDLE;
        r_mem_we <= 1'b0;
        r_mem_re <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_empty) begin
              if (w_ovf_hit) begin
                r_ovf_err <= 1'b1;
              end else if (w_unf_hit) begin
                r_unf_err <= 1'b1;
              end else begin
                r_state     <= ST_ACCESS;
                r_cur_reg   <= w_head.reg_id;
                r_mem_addr  <= w_head.push ? r_sp : (r_sp + ADDR_W'(1));
                r_mem_wdata <= w_head.push ? w_head.data : '0;
                r_mem_we    <= w_head.push;
                r_mem_re    <= ~w_head.push;
              end
            end
          end
          ST_ACCESS: begin
            if (i_mem_ready) begin
              r_state  <= ST_IDLE;
              r_mem_we <= 1'b0;
              r_mem_re <= 1'b0;
              if (r_mem_we) begin
                r_sp <= r_sp - ADDR_W'(1);
              end else begin
                r_sp         <= r_sp + ADDR_W'(1);
                r_pop_valid  <= 1'b1;
                r_pop_data   <= i_mem_rdata;
                r_pop_reg_id <= r_cur_reg;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // One-cycle pulse flagging a dropped command (illegal reg_id or full queue).
  always_ff @(posedge clk) begin
    if (!reset) r_cmd_err <= 1'b0;
    else        r_cmd_err <= w_bad_cmd;
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_we     = r_mem_we;
  assign o_mem_re     = r_mem_re;
  assign o_pop_valid  = r_pop_valid;
  assign o_pop_reg_id = r_pop_reg_id;
  assign o_pop_data   = r_pop_data;
  assign o_sp_out     = r_sp;
  assign o_ovf_err    = r_ovf_err;
  assign o_unf_err    = r_unf_err;
  assign o_cmd_err    = r_cmd_err;
  // Upstream is told to hold once only one free slot remains.
  assign o_stall      = (w_count >= CNT_W'(QDEPTH - 1));

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine with a behavioural data memory.
`timescale 1ns/1ps
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable, i_stack_op, i_push_pop;
  logic [3:0]  i_reg_id;
  logic [15:0] i_gpr_in;
  logic [31:0] i_pc_in;
  logic [3:0]  i_ccr_in;
  logic [11:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_mem_we, o_mem_re;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ready;
  logic        o_pop_valid;
  logic [3:0]  o_pop_reg_id;
  logic [15:0] o_pop_data;
  logic        o_stall;
  logic [11:0] o_sp_out;
  logic        o_ovf_err, o_unf_err, o_cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int          n_we = 0, n_re = 0, n_pops = 0, n_cmd_err = 0;
  logic        both_seen = 1'b0;
  logic [3:0]  pop_ids [16];
  logic [15:0] pop_dat [16];

  logic [15:0] mem [4096];

  always #5 clk = ~clk;

  stack_engine dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_stack_op   (i_stack_op),
    .i_push_pop   (i_push_pop),
    .i_reg_id     (i_reg_id),
    .i_gpr_in     (i_gpr_in),
    .i_pc_in      (i_pc_in),
    .i_ccr_in     (i_ccr_in),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_we     (o_mem_we),
    .o_mem_re     (o_mem_re),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .o_pop_valid  (o_pop_valid),
    .o_pop_reg_id (o_pop_reg_id),
    .o_pop_data   (o_pop_data),
    .o_stall      (o_stall),
    .o_sp_out     (o_sp_out),
    .o_ovf_err    (o_ovf_err),
    .o_unf_err    (o_unf_err),
    .o_cmd_err    (o_cmd_err)
  );

  // Memory model: combinational read, write when a write request meets ready.
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge clk) begin
    if (o_mem_we && i_mem_ready) mem[o_mem_addr] <= o_mem_wdata;
  end

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (o_mem_we) n_we++;
    if (o_mem_re) n_re++;
    if (o_mem_we && o_mem_re) both_seen = 1'b1;
    if (o_cmd_err) n_cmd_err++;
    if (o_pop_valid) begin
      if (n_pops < 16) begin
        pop_ids[n_pops] = o_pop_reg_id;
        pop_dat[n_pops] = o_pop_data;
      end
      n_pops++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic op, input logic push, input logic [3:0] id, input logic [15:0] gpr);
    i_stack_op = op;
    i_push_pop = push;
    i_reg_id   = id;
    i_gpr_in   = gpr;
  endtask

  initial begin
    int p0, we_base, re_base, err_base;
    reset = 1'b0; i_enable = 1'b1; i_mem_ready = 1'b1;
    i_pc_in = 32'h0; i_ccr_in = 4'h0;
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    cyc(3);
    reset = 1'b1;

    // Reset state
    check("rst_sp",    o_sp_out, 12'hFFF);
    check("rst_we",    o_mem_we, 0);
    check("rst_re",    o_mem_re, 0);
    check("rst_addr",  o_mem_addr, 0);
    check("rst_pop",   o_pop_valid, 0);
    check("rst_stall", o_stall, 0);
    check("rst_errs",  {o_ovf_err, o_unf_err, o_cmd_err}, 0);

    // 1: ICU burst CCR, PCL, PCH on consecutive cycles
    i_ccr_in = 4'b1010; i_pc_in = 32'h0001_2345;
    err_base = n_cmd_err;
    drive(1'b1, 1'b1, 4'd10, 16'h0); cyc(1);
    drive(1'b1, 1'b1, 4'd8,  16'h0); cyc(1);
    drive(1'b1, 1'b1, 4'd9,  16'h0); cyc(1);
    drive(1'b0, 1'b0, 4'd0,  16'h0); cyc(10);
    check("t1_mem_fff", mem[12'hFFF], 16'h000A);
    check("t1_mem_ffe", mem[12'hFFE], 16'h2345);
    check("t1_mem_ffd", mem[12'hFFD], 16'h0001);
    check("t1_sp",      o_sp_out, 12'hFFC);
    check("t1_no_cmd_err", n_cmd_err - err_base, 0);

    // 2: pops 9, 8, 10
    p0 = n_pops;
    drive(1'b1, 1'b0, 4'd9,  16'h0); cyc(1);
    drive(1'b1, 1'b0, 4'd8,  16'h0); cyc(1);
    drive(1'b1, 1'b0, 4'd10, 16'h0); cyc(1);
    drive(1'b0, 1'b0, 4'd0,  16'h0); cyc(10);
    check("t2_npops", n_pops - p0, 3);
    check("t2_id0",   pop_ids[p0],     4'd9);
    check("t2_d0",    pop_dat[p0],     16'h0001);
    check("t2_id1",   pop_ids[p0 + 1], 4'd8);
    check("t2_d1",    pop_dat[p0 + 1], 16'h2345);
    check("t2_id2",   pop_ids[p0 + 2], 4'd10);
    check("t2_d2",    pop_dat[p0 + 2], 16'h000A);
    check("t2_sp",    o_sp_out, 12'hFFF);

    // 3: pop on empty stack
    re_base = n_re; p0 = n_pops;
    drive(1'b1, 1'b0, 4'd0, 16'h0); cyc(1);
    drive(1'b0, 1'b0, 4'd0, 16'h0); cyc(5);
    check("t3_unf",    o_unf_err, 1);
    check("t3_no_re",  n_re - re_base, 0);
    check("t3_no_pop", n_pops - p0, 0);
    check("t3_sp",     o_sp_out, 12'hFFF);
    check("t3_ovf",    o_ovf_err, 0);
    cyc(3);
    check("t3_unf_sticky", o_unf_err, 1);

    // 4: memory stalled; one access in flight, then five commands against the queue
    i_mem_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd1, 16'h1111); cyc(1);
    drive(1'b0, 1'b0, 4'd0, 16'h0);    cyc(1);
    check("t4_we",    o_mem_we, 1);
    check("t4_addr",  o_mem_addr, 12'hFFF);
    check("t4_wdata", o_mem_wdata, 16'h1111);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 4'(k + 2), 16'(16'h1111 * (k + 2))); cyc(1);
      check($sformatf("t4_hold_we_%0d", k),   o_mem_we, 1);
      check($sformatf("t4_hold_addr_%0d", k), o_mem_addr, 12'hFFF);
      check($sformatf("t4_stall_%0d", k),     o_stall, (k >= 2) ? 1 : 0);
      check($sformatf("t4_cmd_err_%0d", k),   o_cmd_err, (k == 4) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0); cyc(1);
    check("t4_cmd_err_pulse", o_cmd_err, 0);
    i_mem_ready = 1'b1;
    cyc(14);
    check("t4_mem_fff", mem[12'hFFF], 16'h1111);
    check("t4_mem_ffe", mem[12'hFFE], 16'h2222);
    check("t4_mem_ffd", mem[12'hFFD], 16'h3333);
    check("t4_mem_ffc", mem[12'hFFC], 16'h4444);
    check("t4_mem_ffb", mem[12'hFFB], 16'h5555);
    check("t4_sp",      o_sp_out, 12'hFFA);
    check("t4_stall_clear", o_stall, 0);

    // 5: illegal reg_id
    we_base = n_we;
    drive(1'b1, 1'b1, 4'd12, 16'hBEEF); cyc(1);
    check("t5_cmd_err", o_cmd_err, 1);
    drive(1'b0, 1'b0, 4'd0, 16'h0); cyc(1);
    check("t5_cmd_err_pulse", o_cmd_err, 0);
    cyc(4);
    check("t5_no_access", n_we - we_base, 0);
    check("t5_sp",        o_sp_out, 12'hFFA);

    // 6: enable dropped mid-access, with one more command queued
    i_mem_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd7, 16'h7777); cyc(1);
    drive(1'b1, 1'b1, 4'd0, 16'h0A0A); cyc(1);
    drive(1'b0, 1'b0, 4'd0, 16'h0);
    check("t6_we_inflight",   o_mem_we, 1);
    check("t6_addr_inflight", o_mem_addr, 12'hFFA);
    i_enable = 1'b0;
    cyc(1);
    check("t6_we_drop", o_mem_we, 0);
    check("t6_re_drop", o_mem_re, 0);
    check("t6_sp",      o_sp_out, 12'hFFA);
    i_enable = 1'b1; i_mem_ready = 1'b1;
    we_base = n_we;
    cyc(6);
    check("t6_queue_flushed", n_we - we_base, 0);
    check("t6_sp_after",      o_sp_out, 12'hFFA);
    check("t6_unf_kept",      o_unf_err, 1);
    reset = 1'b0; cyc(1); reset = 1'b1;
    check("t6_rst_sp",   o_sp_out, 12'hFFF);
    check("t6_rst_errs", {o_ovf_err, o_unf_err, o_cmd_err}, 0);

    // 7: fill to SP_LIMIT, then one push too many
    i_mem_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 1'b1, 4'd0, 16'(i)); cyc(1);
      drive(1'b0, 1'b0, 4'd0, 16'h0);  cyc(1);
    end
    cyc(4);
    check("t7_sp_limit", o_sp_out, 12'hBFF);
    check("t7_mem_c00",  mem[12'hC00], 16'd1023);
    check("t7_no_ovf",   o_ovf_err, 0);
    we_base = n_we;
    drive(1'b1, 1'b1, 4'd0, 16'hDEAD); cyc(1);
    drive(1'b0, 1'b0, 4'd0, 16'h0);    cyc(4);
    check("t7_ovf",       o_ovf_err, 1);
    check("t7_no_write",  n_we - we_base, 0);
    check("t7_sp_held",   o_sp_out, 12'hBFF);
    check("t7_unf_clear", o_unf_err, 0);

    check("we_re_exclusive", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
